serial_parity_rx: RTL and testbench
===================================

Name: serial_parity_rx

Overview:
- Serial frame receiver and parity checker; the receiving end of the XOR-based even/odd parity generator used on the lab serial link.
- Accepts a bit stream qualified by a valid strobe: start bit, DATA_W data bits LSB first, parity bit, stop bit.
- Deserialises the word and recomputes the XOR of data and parity bits.
- Reports the word plus parity and framing status with a one-cycle valid pulse.

Parameters:
- DATA_W, 8, number of data bits per frame (1..32).
- ODD, 0, parity sense: 0 = even parity (XOR of data and parity bits must be 0); 1 = odd parity (must be 1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit; sampled only when sin_valid=1.
- sin_valid  input  1  qualifies sin for this cycle; gaps (sin_valid=0) allowed anywhere.
- data_out  output  DATA_W  last completed frame's data word.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity check result of last completed frame.
- frame_err  output  1  stop bit of last completed frame was 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, rst=1): state=IDLE; bit counter=0; shift register=0; parity accumulator=0. Outputs data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
- FSM states: IDLE, DATA, PARITY, STOP. A state advances only on edges where sin_valid=1; otherwise it holds, and counter, shift register and accumulator are all held.
- IDLE:
  - sin_valid=1, sin=1: line idle, ignored.
  - sin_valid=1, sin=0: start bit. Go to DATA; counter=0; shift=0; acc=ODD.
- DATA:
  - Each valid bit is written to shift[counter] (LSB first) and acc ^= sin; counter increments.
  - After the DATA_W-th valid bit, go to PARITY.
- PARITY:
  - On the valid bit, perr = acc ^ sin (1 = error), latched internally. Go to STOP.
- STOP, on the valid bit:
  - data_out <= shift.
  - parity_err <= perr.
  - frame_err <= ~sin.
  - data_valid <= 1 for exactly the next cycle.
  - Go to IDLE.
  - The frame is reported even on a framing error.
- Latency: data_valid is high in the cycle immediately after the edge that samples the stop bit. data_out, parity_err and frame_err are valid in that same cycle. They hold until the next frame completes or reset.
- data_valid is registered and deasserts the following cycle regardless of sin_valid.
- busy is combinational from state: 1 in DATA, PARITY and STOP; 0 in IDLE.
- Back-to-back frames: a start bit presented with sin_valid=1 in the cycle right after the stop bit is accepted. No dead cycle is required.
- Reset mid-frame aborts the partial frame with no data_valid pulse. Previously reported outputs are cleared to 0.
- Counter width is clog2(DATA_W)+1. The counter never wraps within a frame.

Test Plan (DATA_W=8, ODD=0 unless stated):
- Good frame 0xA5: send start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, all with sin_valid=1. Expect data_valid pulse one cycle after stop, data_out=0xA5, parity_err=0, frame_err=0; busy high from the cycle after start through the stop-sampling edge.
- Parity error: 0x07 with parity bit 0 (correct value is 1). Expect data_out=0x07, parity_err=1, frame_err=0. Repeat with parity 1 and expect parity_err=0.
- Framing error plus gaps: 0x3C with valid parity 0 and stop bit 0, with sin_valid dropped for 3 cycles between every bit. Expect exactly one data_valid pulse, data_out=0x3C, frame_err=1, parity_err=0.
- Idle line and back-to-back: 5 cycles of sin=1 valid gives busy=0 and no pulse. Then frames 0x81 and 0x7E with no gap give two pulses, the second with data_out=0x7E and both errors 0.
- Reset mid-frame: assert rst asynchronously after 4 data bits of 0xFF. Expect all outputs 0 and busy=0 immediately and no pulse. A following frame 0x5A (parity 0) is received correctly.
- ODD=1: 0x00 with parity 1 gives parity_err=0; 0x00 with parity 0 gives parity_err=1.

Source files
------------

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, parity bit, stop bit.
// Rebuilds the word, checks even/odd parity and the stop bit, then pulses data_valid.
module serial_parity_rx #(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned     CntW    = $clog2(DATA_W) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              acc_q, acc_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_out_q, perr_out_d;
  logic              ferr_q, ferr_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    // Without a valid strobe every piece of frame state simply holds.
    if (sin_valid) begin
      case (state_q)
        StIdle: begin
          if (!sin) begin
            state_d = StData;
            cnt_d   = '0;
            shift_d = '0;
            acc_d   = ODD;
          end
        end
        StData: begin
          shift_d = shift_q | (DATA_W'(sin) << cnt_q);
          acc_d   = acc_q ^ sin;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            state_d = StParity;
          end
        end
        StParity: begin
          perr_d  = acc_q ^ sin;
          state_d = StStop;
        end
        StStop: begin
          // The frame is reported even when the stop bit is bad.
          data_d     = shift_q;
          perr_out_d = perr_q;
          ferr_d     = ~sin;
          valid_d    = 1'b1;
          state_d    = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx: directed frames plus randomized frames and gaps,
// run against an even-parity and an odd-parity instance sharing the same serial line.
module tb_serial_parity_rx;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sin;
  logic         sin_valid;
  logic [W-1:0] d0, d1;
  logic         v0, v1, pe0, pe1, fe0, fe1, b0, b1;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(W), .ODD(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .data_out  (d0),
    .data_valid(v0),
    .parity_err(pe0),
    .frame_err (fe0),
    .busy      (b0)
  );

  serial_parity_rx #(.DATA_W(W), .ODD(1'b1)) dut_odd (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .data_out  (d1),
    .data_valid(v1),
    .parity_err(pe1),
    .frame_err (fe1),
    .busy      (b1)
  );

  always @(posedge clk) if (v0 === 1'b1) pulses++;

  // Reference rule: XOR of all data bits and the parity bit must equal the parity sense.
  function automatic logic exp_perr(input logic [W-1:0] d, input logic p, input logic odd);
    return ((^d) ^ p) != odd;
  endfunction

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      sin_valid = 1'b0;
      sin       = 1'($urandom);
      @(posedge clk); #1;
    end
    sin       = b;
    sin_valid = 1'b1;
    @(posedge clk); #1;
    sin_valid = 1'b0;
    sin       = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic p, input logic stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < W; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(stop, gap);
  endtask

  task automatic test_reset;
    rst = 1'b1; sin = 1'b1; sin_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({v0, d0, pe0, fe0, b0} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_even: got v=%b d=%h pe=%b fe=%b busy=%b, need all 0",
               v0, d0, pe0, fe0, b0);
    end
    checks++;
    if ({v1, d1, pe1, fe1, b1} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_odd: got v=%b d=%h pe=%b fe=%b busy=%b, need all 0",
               v1, d1, pe1, fe1, b1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    logic [W-1:0] d = 8'hA5;
    send_bit(1'b0, 0);
    checks++;
    if (b0 !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b need 1", b0);
    end
    for (int i = 0; i < W; i++) send_bit(d[i], 0);
    send_bit(1'b0, 0);
    checks++;
    if (b0 !== 1'b1 || v0 !== 1'b0) begin
      errors++; $display("FAIL busy_before_stop: got busy=%b v=%b need 1 0", b0, v0);
    end
    send_bit(1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0, b0} !== {1'b1, 8'hA5, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL good_a5: got v=%b d=%h pe=%b fe=%b busy=%b need 1 a5 0 0 0",
               v0, d0, pe0, fe0, b0);
    end
    @(posedge clk); #1;
    checks++;
    if ({v0, d0} !== {1'b0, 8'hA5}) begin
      errors++; $display("FAIL pulse_drop: got v=%b d=%h need 0 a5", v0, d0);
    end
  endtask

  task automatic test_parity_err;
    send_frame(8'h07, 1'b0, 1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h07, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL perr_07_p0: got v=%b d=%h pe=%b fe=%b need 1 07 1 0", v0, d0, pe0, fe0);
    end
    send_frame(8'h07, 1'b1, 1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL perr_07_p1: got v=%b d=%h pe=%b fe=%b need 1 07 0 0", v0, d0, pe0, fe0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_framing_gaps;
    int snap = pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 3);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL frame_3c: got v=%b d=%h pe=%b fe=%b need 1 3c 0 1", v0, d0, pe0, fe0);
    end
    @(posedge clk); #1;
    checks++;
    if (pulses - snap != 1 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL frame_3c_pulses: got %0d pulses v=%b need 1 pulse v=0", pulses - snap, v0);
    end
  endtask

  task automatic test_idle_back_to_back;
    int snap = pulses;
    repeat (5) send_bit(1'b1, 0);
    checks++;
    if (b0 !== 1'b0 || pulses != snap) begin
      errors++;
      $display("FAIL idle_line: got busy=%b pulses=%0d need 0 0", b0, pulses - snap);
    end
    send_frame(8'h81, even_par(8'h81), 1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h81, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_81: got v=%b d=%h pe=%b fe=%b need 1 81 0 0", v0, d0, pe0, fe0);
    end
    send_frame(8'h7E, even_par(8'h7E), 1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h7E, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_7e: got v=%b d=%h pe=%b fe=%b need 1 7e 0 0", v0, d0, pe0, fe0);
    end
    @(posedge clk); #1;
    checks++;
    if (pulses - snap != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d need 2", pulses - snap);
    end
  endtask

  task automatic test_reset_mid_frame;
    int snap = pulses;
    send_bit(1'b0, 0);
    repeat (4) send_bit(1'b1, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({v0, d0, pe0, fe0, b0} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got v=%b d=%h pe=%b fe=%b busy=%b need all 0",
               v0, d0, pe0, fe0, b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pulses != snap) begin
      errors++; $display("FAIL mid_reset_pulse: got %0d pulses need 0", pulses - snap);
    end
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    checks++;
    if ({v0, d0, pe0, fe0} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_5a: got v=%b d=%h pe=%b fe=%b need 1 5a 0 0", v0, d0, pe0, fe0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_odd;
    send_frame(8'h00, 1'b1, 1'b1, 0);
    checks++;
    if ({v1, d1, pe1, pe0} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL odd_00_p1: got v=%b d=%h pe_odd=%b pe_even=%b need 1 00 0 1",
               v1, d1, pe1, pe0);
    end
    send_frame(8'h00, 1'b0, 1'b1, 0);
    checks++;
    if ({v1, d1, pe1, pe0} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL odd_00_p0: got v=%b d=%h pe_odd=%b pe_even=%b need 1 00 1 0",
               v1, d1, pe1, pe0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int snap = pulses;
    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] d    = W'($urandom);
      logic         p    = 1'($urandom);
      logic         stop = 1'($urandom_range(0, 3) != 0);
      int           gap  = int'($urandom_range(0, 2));
      send_frame(d, p, stop, gap);
      checks++;
      if ({v0, d0, pe0, fe0} !== {1'b1, d, exp_perr(d, p, 1'b0), ~stop}) begin
        errors++;
        $display("FAIL rand_even[%0d]: got v=%b d=%h pe=%b fe=%b need 1 %h %b %b",
                 n, v0, d0, pe0, fe0, d, exp_perr(d, p, 1'b0), ~stop);
      end
      checks++;
      if ({v1, d1, pe1, fe1} !== {1'b1, d, exp_perr(d, p, 1'b1), ~stop}) begin
        errors++;
        $display("FAIL rand_odd[%0d]: got v=%b d=%h pe=%b fe=%b need 1 %h %b %b",
                 n, v1, d1, pe1, fe1, d, exp_perr(d, p, 1'b1), ~stop);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (pulses - snap != 24) begin
      errors++; $display("FAIL rand_pulses: got %0d need 24", pulses - snap);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_framing_gaps();
    test_idle_back_to_back();
    test_reset_mid_frame();
    test_odd();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
